// File: rtl/jk_toggle_monitor_if.sv
// Report port of the JK toggle monitor.
// Counts and error flag travel with a valid/ready handshake.
interface jk_toggle_monitor_if #(
  parameter int CNT_W = 8
);
  logic             rpt_valid;
  logic             rpt_ready;
  logic [CNT_W-1:0] rpt_rise;
  logic [CNT_W-1:0] rpt_fall;
  logic [CNT_W-1:0] rpt_mism;
  logic             rpt_nerr;

  modport master (
    output rpt_valid,
    output rpt_rise,
    output rpt_fall,
    output rpt_mism,
    output rpt_nerr,
    input  rpt_ready
  );

  modport slave (
    input  rpt_valid,
    input  rpt_rise,
    input  rpt_fall,
    input  rpt_mism,
    input  rpt_nerr,
    output rpt_ready
  );
endinterface

// File: rtl/jk_toggle_monitor.sv
// Checks a JK flop against its truth table and counts
// q edges over a window, reporting through valid/ready.
module jk_toggle_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic ff_reset,
  input  logic j,
  input  logic k,
  input  logic q,
  input  logic qnot,
  input  logic start,
  output logic busy,
  jk_toggle_monitor_if.master rpt
);

  localparam int WC_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WC_W-1:0] WIN_LAST = WC_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    REPORT  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WC_W-1:0]  win_q, win_d;
  logic [CNT_W-1:0] rise_q, rise_d;
  logic [CNT_W-1:0] fall_q, fall_d;
  logic [CNT_W-1:0] mism_q, mism_d;
  logic             nerr_q, nerr_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;

  logic hv_q;
  logic pj_q;
  logic pk_q;
  logic pq_q;
  logic pr_q;

  logic pred_s;
  logic mis_s;
  logic rise_s;
  logic fall_s;
  logic nerr_s;
  logic win_last;
  logic hs_s;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    if (en && (v != CMAX)) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  // Expected q for this cycle from last cycle's flop inputs
  always_comb begin
    pred_s = pq_q;
    unique case ({pj_q, pk_q})
      2'b00:   pred_s = pq_q;
      2'b01:   pred_s = 1'b0;
      2'b10:   pred_s = 1'b1;
      default: pred_s = ~pq_q;
    endcase
    if (pr_q) begin
      pred_s = 1'b0;
    end
  end

  assign mis_s    = hv_q & (q != pred_s);
  assign rise_s   = hv_q & ~pq_q & q;
  assign fall_s   = hv_q & pq_q & ~q;
  assign nerr_s   = (qnot == q);
  assign win_last = (win_q == WIN_LAST);
  assign hs_s     = valid_q & rpt.rpt_ready;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    mism_d  = mism_q;
    nerr_d  = nerr_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = MEASURE;
          win_d   = '0;
          rise_d  = '0;
          fall_d  = '0;
          mism_d  = '0;
          nerr_d  = 1'b0;
        end
      end
      MEASURE: begin
        rise_d = sat_inc(rise_q, rise_s);
        fall_d = sat_inc(fall_q, fall_s);
        mism_d = sat_inc(mism_q, mis_s);
        nerr_d = nerr_q | nerr_s;
        win_d  = win_q + WC_W'(1);
        if (win_last) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (hs_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_d  = (state_d != IDLE);
  assign valid_d = (state_d == REPORT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      win_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      mism_q  <= '0;
      nerr_q  <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      hv_q    <= 1'b0;
      pj_q    <= 1'b0;
      pk_q    <= 1'b0;
      pq_q    <= 1'b0;
      pr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      mism_q  <= mism_d;
      nerr_q  <= nerr_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      hv_q    <= 1'b1;
      pj_q    <= j;
      pk_q    <= k;
      pq_q    <= q;
      pr_q    <= ff_reset;
    end
  end

  assign busy          = busy_q;
  assign rpt.rpt_valid = valid_q;
  assign rpt.rpt_rise  = rise_q;
  assign rpt.rpt_fall  = fall_q;
  assign rpt.rpt_mism  = mism_q;
  assign rpt.rpt_nerr  = nerr_q;

endmodule

// File: tb/tb_jk_toggle_monitor.sv
// Bench for jk_toggle_monitor: a behavioural JK flop drives
// two monitors; each window is re-counted from a cycle log.
module tb_jk_toggle_monitor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic ff_reset;
  logic j;
  logic k;
  logic q;
  logic qnot;
  logic start_a;
  logic start_b;
  logic busy_a;
  logic busy_b;

  jk_toggle_monitor_if #(.CNT_W(8)) ra ();
  jk_toggle_monitor_if #(.CNT_W(3)) rb ();

  jk_toggle_monitor #(
    .CNT_W (8),
    .WINDOW(16)
  ) dut_a (
    .clk     (clk),
    .reset   (reset),
    .ff_reset(ff_reset),
    .j       (j),
    .k       (k),
    .q       (q),
    .qnot    (qnot),
    .start   (start_a),
    .busy    (busy_a),
    .rpt     (ra.master)
  );

  jk_toggle_monitor #(
    .CNT_W (3),
    .WINDOW(32)
  ) dut_b (
    .clk     (clk),
    .reset   (reset),
    .ff_reset(ff_reset),
    .j       (j),
    .k       (k),
    .q       (q),
    .qnot    (qnot),
    .start   (start_b),
    .busy    (busy_b),
    .rpt     (rb.master)
  );

  int checks = 0;
  int fails  = 0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  // per-cycle log of what the monitors were shown
  bit lj   [8192];
  bit lk   [8192];
  bit lffr [8192];
  bit lrst [8192];
  bit lq   [8192];
  bit lqn  [8192];
  int cyc = 0;

  bit fq   = 1'b0;
  bit pj_t = 1'b0;
  bit pk_t = 1'b0;
  bit pr_t = 1'b1;

  bit s_j, s_k, s_ffr, s_qe, s_ne, s_rst;

  task automatic apply(input bit sa, input bit sb,
                       input bit rdy_a, input bit rdy_b);
    bit qd;
    if (pr_t) fq = 1'b0;
    else if (pj_t && pk_t) fq = ~fq;
    else if (pj_t) fq = 1'b1;
    else if (pk_t) fq = 1'b0;
    qd = fq ^ s_qe;
    q = qd;
    qnot = ~qd ^ s_ne;
    j = s_j;
    k = s_k;
    ff_reset = s_ffr;
    reset = s_rst;
    start_a = sa;
    start_b = sb;
    ra.rpt_ready = rdy_a;
    rb.rpt_ready = rdy_b;
    lj[cyc] = s_j;
    lk[cyc] = s_k;
    lffr[cyc] = s_ffr;
    lrst[cyc] = s_rst;
    lq[cyc] = qd;
    lqn[cyc] = ~qd ^ s_ne;
    pj_t = s_j;
    pk_t = s_k;
    pr_t = s_ffr;
    cyc++;
  endtask

  task automatic gen(input int mode, input int i);
    s_ffr = 1'b0;
    s_qe  = 1'b0;
    s_ne  = 1'b0;
    s_rst = 1'b0;
    s_j   = 1'b1;
    s_k   = 1'b1;
    case (mode)
      1: begin s_j = 1'b0; s_k = 1'b0; end
      2: begin s_j = 1'b1; s_k = 1'b0; end
      3: s_qe = (i == 5);
      4: s_ne = (i == 3);
      5: begin
        s_j   = 1'($urandom % 2);
        s_k   = 1'($urandom % 2);
        s_ffr = ($urandom % 8) == 0;
        s_qe  = ($urandom % 12) == 0;
        s_ne  = ($urandom % 16) == 0;
      end
      6: begin
        s_j = 1'b0;
        s_k = 1'b0;
        s_ffr = (i == 10);
      end
      default: ;
    endcase
  endtask

  // One cycle that leaves the flop showing qv next cycle
  task automatic prep(input bit qv);
    @(negedge clk);
    gen(1, 0);
    if (qv) s_j = 1'b1;
    else s_ffr = 1'b1;
    apply(0, 0, 0, 0);
  endtask

  task automatic win_exp(input int s, input int w, input int cw,
                         output int er, output int ef,
                         output int em, output int en);
    int mx;
    bit pred;
    er = 0; ef = 0; em = 0; en = 0;
    for (int t = s + 1; t <= s + w; t++) begin
      if (lqn[t] == lq[t]) en = 1;
      if (!lrst[t-1]) begin
        pred = lffr[t-1] ? 1'b0 :
               ((lj[t-1] & ~lq[t-1]) | (~lk[t-1] & lq[t-1]));
        if (!lq[t-1] && lq[t]) er++;
        if (lq[t-1] && !lq[t]) ef++;
        if (lq[t] != pred) em++;
      end
    end
    mx = (1 << cw) - 1;
    if (er > mx) er = mx;
    if (ef > mx) ef = mx;
    if (em > mx) em = mx;
  endtask

  function automatic logic [31:0] busy_of(input int d);
    return d ? 32'(busy_b) : 32'(busy_a);
  endfunction
  function automatic logic [31:0] valid_of(input int d);
    return d ? 32'(rb.rpt_valid) : 32'(ra.rpt_valid);
  endfunction
  function automatic logic [31:0] rise_of(input int d);
    return d ? 32'(rb.rpt_rise) : 32'(ra.rpt_rise);
  endfunction
  function automatic logic [31:0] fall_of(input int d);
    return d ? 32'(rb.rpt_fall) : 32'(ra.rpt_fall);
  endfunction
  function automatic logic [31:0] mism_of(input int d);
    return d ? 32'(rb.rpt_mism) : 32'(ra.rpt_mism);
  endfunction
  function automatic logic [31:0] nerr_of(input int d);
    return d ? 32'(rb.rpt_nerr) : 32'(ra.rpt_nerr);
  endfunction

  task automatic chk_fields(input string tg, input int d,
                            input int er, input int ef,
                            input int em, input int en);
    chk({tg, "_rise"}, rise_of(d), er);
    chk({tg, "_fall"}, fall_of(d), ef);
    chk({tg, "_mism"}, mism_of(d), em);
    chk({tg, "_nerr"}, nerr_of(d), en);
  endtask

  task automatic measure(input int d, input int mode,
                         input int abort_at, input int hold);
    int w, s, er, ef, em, en;
    bit p;
    w = d ? 32 : 16;
    @(negedge clk);
    gen(mode, 0);
    s = cyc;
    apply(d == 0, d == 1, 0, 0);
    for (int i = 1; i <= w; i++) begin
      @(negedge clk);
      chk("busy_meas", busy_of(d), 1);
      chk("valid_meas", valid_of(d), 0);
      gen(mode, i);
      if (i == abort_at) begin
        s_rst = 1'b1;
        apply(0, 0, 0, 0);
        @(negedge clk);
        chk("abort_busy", busy_of(d), 0);
        chk("abort_valid", valid_of(d), 0);
        chk_fields("abort", d, 0, 0, 0, 0);
        gen(mode, i + 1);
        apply(0, 0, 0, 0);
        return;
      end
      apply(0, 0, 0, 0);
    end
    win_exp(s, w, d ? 3 : 8, er, ef, em, en);
    for (int h = 0; h <= hold; h++) begin
      @(negedge clk);
      chk("valid_rpt", valid_of(d), 1);
      chk("busy_rpt", busy_of(d), 1);
      chk_fields("rpt", d, er, ef, em, en);
      gen(mode, w + 1 + h);
      p = 1'($urandom % 2);
      if (h == hold)
        apply(d == 0 && p, d == 1 && p, d == 0, d == 1);
      else
        apply(d == 0 && p, d == 1 && p, 0, 0);
    end
    @(negedge clk);
    chk("valid_drop", valid_of(d), 0);
    chk("busy_idle", busy_of(d), 0);
    chk_fields("kept", d, er, ef, em, en);
    gen(mode, w + hold + 2);
    apply(0, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    gen(1, 0);
    s_rst = 1'b1;
    apply(0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      gen(1, 0);
      s_rst = 1'b1;
      apply(0, 0, 0, 0);
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", busy_of(d), 0);
      chk("rst_valid", valid_of(d), 0);
      chk_fields("rst", d, 0, 0, 0, 0);
    end
    gen(1, 0);
    apply(0, 0, 0, 0);

    prep(0);
    measure(0, 0, 0, 2);
    chk_fields("t1", 0, 8, 8, 0, 0);

    prep(1);
    measure(0, 1, 0, 1);
    chk_fields("t2hold", 0, 0, 0, 0, 0);
    prep(0);
    measure(0, 2, 0, 0);
    chk("t2set_rise", rise_of(0), 1);
    chk("t2set_fall", fall_of(0), 0);

    prep(0);
    measure(0, 3, 0, 0);
    chk("t3_mism", mism_of(0), 2);
    measure(0, 4, 0, 0);
    chk("t3_nerr", nerr_of(0), 1);
    chk("t3_nerr_mism", mism_of(0), 0);

    measure(0, 5, 0, 10);

    prep(0);
    measure(0, 0, 7, 0);
    prep(0);
    measure(0, 0, 0, 1);
    chk_fields("t5", 0, 8, 8, 0, 0);

    prep(0);
    measure(1, 0, 0, 1);
    chk("t6_rise", rise_of(1), 7);
    chk("t6_fall", fall_of(1), 7);
    prep(1);
    measure(1, 6, 0, 1);
    chk_fields("t6ffr", 1, 0, 1, 0, 0);

    repeat (24) begin
      int d, ab;
      d = int'($urandom % 2);
      ab = (($urandom % 6) == 0) ?
           int'($urandom_range(1, d ? 32 : 16)) : 0;
      measure(d, 5, ab, int'($urandom % 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
